// File: rtl/led_matrix_refresh_ctrl.sv
// SPI master and frame sequencer for the 104x16 LED matrix receiver.
// Sends one intensity frame {FF, intensity}, then 208 pixel frames {addr, fb_data}.
module led_matrix_refresh_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       intensity_only,
  input  logic [7:0] intensity,
  output logic [7:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done
);

  localparam int PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] DIV_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_END = PW'(CS_GAP - 1);
  localparam logic [7:0]    LAST_PIX = 8'd208;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_t;

  state_t        state;
  logic [PW-1:0] ph;
  logic [15:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [7:0]    frame_idx;
  logic          io_q;
  logic          last_frame;

  assign last_frame = io_q ? (frame_idx == 8'd0) : (frame_idx == LAST_PIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_idx <= '0;
      io_q      <= 1'b0;
      fb_addr   <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            io_q      <= intensity_only;
            frame_idx <= '0;
            shreg     <= {8'hFF, intensity};
            bit_cnt   <= '0;
            ph        <= '0;
            cs        <= 1'b0;
            mosi      <= 1'b1;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (ph == DIV_END) begin
            ph    <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else ph <= ph + 1'b1;
        end
        HIGH: begin
          if (ph == DIV_END) begin
            ph   <= '0;
            sclk <= 1'b0;
            if (bit_cnt == 4'd15) state <= TAIL;
            else begin
              // next bit goes out on the falling edge, half a period before the receiver samples
              shreg   <= shreg << 1;
              mosi    <= shreg[14];
              bit_cnt <= bit_cnt + 1'b1;
              state   <= LOW;
            end
          end else ph <= ph + 1'b1;
        end
        LOW: begin
          if (ph == DIV_END) begin
            ph    <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else ph <= ph + 1'b1;
        end
        TAIL: begin
          if (ph == DIV_END) begin
            ph    <= '0;
            cs    <= 1'b1;
            mosi  <= 1'b0;
            state <= GAP;
            // pixel frame n carries address n-1, so the next address is the current index
            if (!last_frame) fb_addr <= frame_idx;
          end else ph <= ph + 1'b1;
        end
        GAP: begin
          if (ph == GAP_END) begin
            ph <= '0;
            if (last_frame) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              frame_idx <= frame_idx + 1'b1;
              shreg     <= {fb_addr, fb_data};
              mosi      <= fb_addr[7];
              bit_cnt   <= '0;
              cs        <= 1'b0;
              state     <= SETUP;
            end
          end else ph <= ph + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
